// File: rtl/phy_mgmt_ctrl.sv
// PHY management controller: waits out PHY reset, writes BMCR once, then polls BMSR and the
// vendor status register over MDIO to report link state and speed.
module phy_mgmt_ctrl #(
    parameter int unsigned REFCLK_HZ = 300000000,
    parameter int unsigned MDC_HZ    = 2500000,
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter int unsigned SETTLE_MS = 10,
    parameter int unsigned POLL_MS   = 100,
    parameter logic [15:0] BMCR_INIT = 16'h1140,
    parameter logic [4:0]  PHYSR_REG = 5'h11
) (
    input  logic       clk,
    input  logic       rstn_in,
    input  logic       phy_rstn,
    output logic       mdc,
    output logic       mdio_o,
    output logic       mdio_oe,
    input  logic       mdio_i,
    output logic       init_done,
    output logic       link_up,
    output logic [1:0] speed,
    output logic       busy
);

    localparam int unsigned HALF        = REFCLK_HZ / (2 * MDC_HZ);
    localparam int unsigned CLKS_PER_MS = REFCLK_HZ / 1000;
    localparam logic [15:0] HALF_LAST   = 16'(HALF - 1);
    localparam logic [31:0] MS_LAST     = 32'(CLKS_PER_MS - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_MS - 1);
    localparam logic [31:0] POLL_LAST   = 32'(POLL_MS - 1);

    typedef enum logic [2:0] {
        StWaitRst, StSettle, StWrBmcr, StPollWait, StRdBmsr, StRdPhysr
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] clk_cnt_q, clk_cnt_d, ms_cnt_q, ms_cnt_d;
    logic        init_q, init_d, link_q, link_d;
    logic [1:0]  speed_q, speed_d;
    logic        pend_q, pend_d;
    logic        busy_q, busy_d, mdc_q, mdc_d, mdo_q, mdo_d, oe_q, oe_d;
    logic [5:0]  bit_q, bit_d;
    logic [15:0] hcnt_q, hcnt_d, rx_q, rx_d;
    logic        tick, mdc_edge, frame_done, start, cur_frame, next_frame, is_wr, tx_bit;
    logic [4:0]  reg_addr;
    logic [63:0] tx_frame;

    function automatic logic is_frame(state_t s);
        return s inside {StWrBmcr, StRdBmsr, StRdPhysr};
    endfunction

    assign tick       = (clk_cnt_q == MS_LAST);
    assign mdc_edge   = busy_q && (hcnt_q == HALF_LAST);
    assign frame_done = mdc_edge && mdc_q && (bit_q == 6'd63);

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        link_d  = link_q;
        speed_d = speed_q;
        case (state_q)
            StWaitRst:  if (phy_rstn) state_d = StSettle;
            StSettle:   if (tick && ms_cnt_q == SETTLE_LAST) state_d = StWrBmcr;
            StWrBmcr: if (frame_done) begin
                init_d  = 1'b1;
                state_d = StRdBmsr;
            end
            StRdBmsr: if (frame_done) begin
                link_d  = rx_q[2];
                state_d = StRdPhysr;
            end
            StRdPhysr: if (frame_done) begin
                speed_d = link_q ? rx_q[15:14] : 2'b00;
                state_d = StPollWait;
            end
            StPollWait: if (tick && ms_cnt_q == POLL_LAST) state_d = StRdBmsr;
            default:    state_d = StWaitRst;
        endcase
        if (!phy_rstn) begin
            state_d = StWaitRst;
            init_d  = 1'b0;
            link_d  = 1'b0;
            speed_d = 2'b00;
        end
    end

    // Back-to-back frames are separated by one idle clk so busy and mdio_oe drop between them.
    always_comb begin
        cur_frame  = is_frame(state_q);
        next_frame = is_frame(state_d);
        start      = phy_rstn && (((state_d != state_q) && next_frame && !cur_frame) || pend_q);
        pend_d     = phy_rstn && (state_d != state_q) && next_frame && cur_frame;
        clk_cnt_d  = '0;
        ms_cnt_d   = '0;
        if (state_d == state_q && state_q inside {StSettle, StPollWait}) begin
            clk_cnt_d = tick ? 32'd0 : clk_cnt_q + 32'd1;
            ms_cnt_d  = tick ? ms_cnt_q + 32'd1 : ms_cnt_q;
        end
    end

    always_comb begin
        is_wr    = (state_q == StWrBmcr);
        reg_addr = (state_q == StRdPhysr) ? PHYSR_REG : (is_wr ? 5'd0 : 5'd1);
        tx_frame = is_wr ? {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, reg_addr, 2'b10, BMCR_INIT}
                         : {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, reg_addr, 18'h3FFFF};
        tx_bit   = tx_frame[~bit_q];
        busy_d   = busy_q;
        mdc_d    = mdc_q;
        mdo_d    = mdo_q;
        oe_d     = oe_q;
        bit_d    = bit_q;
        hcnt_d   = hcnt_q;
        rx_d     = rx_q;
        if (!phy_rstn) begin
            busy_d = 1'b0;
            mdc_d  = 1'b0;
            mdo_d  = 1'b1;
            oe_d   = 1'b0;
            bit_d  = '0;
            hcnt_d = '0;
        end else if (start) begin
            busy_d = 1'b1;
            mdc_d  = 1'b0;
            mdo_d  = 1'b1;
            oe_d   = 1'b1;
            bit_d  = '0;
            hcnt_d = '0;
            rx_d   = '0;
        end else if (busy_q) begin
            hcnt_d = hcnt_q + 16'd1;
            // Data moves only in the low phase, so it is settled before the next rising edge.
            if (!mdc_q) begin
                mdo_d = tx_bit;
                oe_d  = is_wr || (bit_q < 6'd46);
            end
            if (mdc_edge) begin
                hcnt_d = '0;
                mdc_d  = !mdc_q;
                if (!mdc_q) begin
                    rx_d = {rx_q[14:0], mdio_i};
                end else if (bit_q == 6'd63) begin
                    busy_d = 1'b0;
                    mdo_d  = 1'b1;
                    oe_d   = 1'b0;
                    bit_d  = '0;
                end else begin
                    bit_d = bit_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q   <= StWaitRst;
            clk_cnt_q <= '0;
            ms_cnt_q  <= '0;
            init_q    <= 1'b0;
            link_q    <= 1'b0;
            speed_q   <= 2'b00;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            mdc_q     <= 1'b0;
            mdo_q     <= 1'b1;
            oe_q      <= 1'b0;
            bit_q     <= '0;
            hcnt_q    <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            ms_cnt_q  <= ms_cnt_d;
            init_q    <= init_d;
            link_q    <= link_d;
            speed_q   <= speed_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            mdc_q     <= mdc_d;
            mdo_q     <= mdo_d;
            oe_q      <= oe_d;
            bit_q     <= bit_d;
            hcnt_q    <= hcnt_d;
            rx_q      <= rx_d;
        end
    end

    assign mdc       = mdc_q;
    assign mdio_o    = mdo_q;
    assign mdio_oe   = oe_q;
    assign init_done = init_q;
    assign link_up   = link_q;
    assign speed     = speed_q;
    assign busy      = busy_q;

endmodule
